// File: rtl/brick_pkg.sv
// Shared types and screen constants for the rectangle plotter and its command FIFO.
package brick_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int DIM_W    = 5;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [DIM_W-1:0]    w;
    logic [DIM_W-1:0]    h;
    logic [COLOUR_W-1:0] colour;
  } rect_cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with occupancy counter, flush, and async active-low reset.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    ptr_inc = (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];
  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);

  // Storage array write port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_ok_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Queues rectangle fill commands and rasterises them into one clipped pixel per cycle.
module rect_plotter
  import brick_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [X_W-1:0]      cmd_x,
  input  logic [Y_W-1:0]      cmd_y,
  input  logic [DIM_W-1:0]    cmd_w,
  input  logic [DIM_W-1:0]    cmd_h,
  input  logic [COLOUR_W-1:0] cmd_colour,
  input  logic                abort,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  state_e         state_r;
  state_e         next_state_s;
  rect_cmd_t      base_r;
  rect_cmd_t      cmd_s;
  rect_cmd_t      head_s;
  logic [DIM_W-1:0] cx_r;
  logic [DIM_W-1:0] cy_r;
  logic           ready_en_r;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic           push_s;
  logic           pop_s;
  logic           last_s;
  logic [X_W:0]   x_sum_s;
  logic [Y_W:0]   y_sum_s;

  assign cmd_s     = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, colour: cmd_colour};
  assign cmd_ready = ready_en_r && !fifo_full_s && !abort;
  assign push_s    = cmd_valid && cmd_ready;
  assign last_s    = (state_r == DRAW) && (cx_r == base_r.w) && (cy_r == base_r.h);
  // A pop on the last pixel chains straight into the next rectangle.
  assign pop_s     = !abort && !fifo_empty_s && ((state_r == IDLE) || last_s);
  assign busy      = (state_r == DRAW) || !fifo_empty_s;
  assign x_sum_s   = {1'b0, base_r.x} + (X_W + 1)'(cx_r);
  assign y_sum_s   = {1'b0, base_r.y} + (Y_W + 1)'(cy_r);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(rect_cmd_t))
  ) u_cmd_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (abort),
    .push   (push_s),
    .din    (cmd_s),
    .pop    (pop_s),
    .dout   (head_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

  // Holds cmd_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ready_en_r <= 1'b0;
    else         ready_en_r <= 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= IDLE;
    else         state_r <= next_state_s;
  end

  // Next-state logic and pixel outputs
  always_comb begin
    next_state_s = state_r;
    x            = '0;
    y            = '0;
    colour       = '0;
    plot         = 1'b0;
    done         = 1'b0;
    if (abort) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = fifo_empty_s ? IDLE : DRAW;
        DRAW:    next_state_s = (last_s && fifo_empty_s) ? IDLE : DRAW;
        default: next_state_s = IDLE;
      endcase
    end
    if (state_r == DRAW) begin
      x      = x_sum_s[X_W-1:0];
      y      = y_sum_s[Y_W-1:0];
      colour = base_r.colour;
      plot   = !abort && (x_sum_s < (X_W + 1)'(SCREEN_W)) && (y_sum_s < (Y_W + 1)'(SCREEN_H));
      done   = !abort && last_s;
    end else begin
      plot   = 1'b0;
    end
  end

  // Rectangle base registers and raster counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      base_r <= '0;
      cx_r   <= '0;
      cy_r   <= '0;
    end else if (abort) begin
      cx_r <= '0;
      cy_r <= '0;
    end else if (pop_s) begin
      base_r <= head_s;
      cx_r   <= '0;
      cy_r   <= '0;
    end else if (last_s) begin
      cx_r <= '0;
      cy_r <= '0;
    end else if (state_r == DRAW) begin
      if (cx_r == base_r.w) begin
        cx_r <= '0;
        cy_r <= cy_r + DIM_W'(1);
      end else begin
        cx_r <= cx_r + DIM_W'(1);
      end
    end
  end

endmodule

// File: doc/rect_plotter.md
RECT_PLOTTER -- requirements
Module: rect_plotter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock (CLOCK_50 domain).
REQ-002 SHALL have port resetn, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port cmd_valid, input, 1 bit: rectangle command offered.
REQ-004 SHALL have port cmd_ready, output, 1 bit: command accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-005 SHALL have port cmd_x, input, 8 bits: top-left x.
REQ-006 SHALL have port cmd_y, input, 7 bits: top-left y.
REQ-007 SHALL have port cmd_w, input, 5 bits: width minus 1 (1..32 px).
REQ-008 SHALL have port cmd_h, input, 5 bits: height minus 1 (1..32 px).
REQ-009 SHALL have port cmd_colour, input, 3 bits: RGB fill colour.
REQ-010 SHALL have port abort, input, 1 bit: synchronous flush of the current rectangle and all queued commands.
REQ-011 SHALL have port x, output, 8 bits: pixel x, to vga_adapter.
REQ-012 SHALL have port y, output, 7 bits: pixel y, to vga_adapter.
REQ-013 SHALL have port colour, output, 3 bits: pixel colour, to vga_adapter.
REQ-014 SHALL have port plot, output, 1 bit: pixel write strobe, to vga_adapter.
REQ-015 SHALL have port busy, output, 1 bit: high while in DRAW or while the FIFO is non-empty.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse during the last pixel cycle of each rectangle.
REQ-017 SHALL have parameter FIFO_DEPTH, default 4: number of queued commands.

Function
REQ-018 SHALL buffer accepted commands in a FIFO_DEPTH-entry FIFO; cmd_ready = !fifo_full && !abort.
REQ-019 SHALL allow a push and a pop in the same cycle when the FIFO is not full; occupancy is then unchanged.
REQ-020 SHALL use two states: IDLE and DRAW.
REQ-021 IDLE with FIFO non-empty: pop the head on the next edge, load base x/y/w/h/colour, clear counters cx and cy, enter DRAW.
REQ-022 DRAW: emit exactly one pixel per cycle in raster order, cx incrementing fastest; when cx==w, clear cx and increment cy.
REQ-023 Pixel coordinates: x = base_x + cx, y = base_y + cy, computed at 9/8-bit width with no wrap-around.
REQ-024 Clipping: plot = DRAW && x_sum<160 && y_sum<120; clipped pixels still consume their cycle, and x/y/colour are driven but not plotted.
REQ-025 Last pixel (cx==w && cy==h): assert done; if the FIFO is non-empty, pop and load the next command on the same edge with no idle bubble; otherwise go to IDLE.
REQ-026 Latency: a command accepted in cycle N into an empty FIFO with the block IDLE produces its first pixel in cycle N+2.
REQ-027 A rectangle SHALL occupy exactly (w+1)*(h+1) DRAW cycles.
REQ-028 abort: on the next edge, empty the FIFO and enter IDLE; plot and done are forced low in the abort cycle; abort wins over a simultaneous cmd_valid or last pixel.
REQ-029 When not in DRAW: plot=0, done=0, and x, y, colour hold 0.

Reset
REQ-030 resetn low SHALL immediately force state IDLE, an empty FIFO, cx=cy=0, x=y=colour=0, plot=done=busy=0, and cmd_ready=0.
REQ-031 cmd_ready SHALL rise on the first edge after resetn deasserts; reset mid-rectangle SHALL discard all pending work.

Structure
REQ-032 Shared package brick_pkg SHALL hold SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOUR_W=3, the rectangle command struct, and the IDLE/DRAW state enum.
REQ-033 The FIFO SHALL be a separate sub-module cmd_fifo (parameterised depth and width, async active-low reset, full/empty flags).

Verification
REQ-034 Single brick: push (16,8,w=15,h=3,colour=100) at cycle N -> 64 plots from cycle N+2, first (16,8), last (31,11), done on the 64th plot only, busy low afterwards.
REQ-035 Clipping: push (152,0,w=15,h=0) -> 16 DRAW cycles, plot high for x=152..159 only, done on the 16th cycle.
REQ-036 FIFO full: push 5 commands back-to-back while the first draws -> cmd_ready low after the 5th is accepted, then all 5 rectangles are drawn in order with no gaps.
REQ-037 Back-to-back: two 1x1 commands, (0,0) and (1,0) -> plots on consecutive cycles and two done pulses.
REQ-038 Abort: assert abort during pixel 10 of a 64-pixel rectangle with 2 queued -> plot low in that cycle and after, busy=0 next cycle, no further plots.
REQ-039 Reset mid-draw: pull resetn low asynchronously -> all outputs 0 before the next edge; after release a new command draws normally.
